// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequencer for an iterative AES-128 round datapath.
// Takes one block from upstream, then issues NUM_ROUNDS+1 passes through the
// shared SubBytes/ShiftRows/MixColumns/AddRoundKey datapath. Pass 0 is the
// initial AddRoundKey on the upstream block. Passes 1..NUM_ROUNDS-1 are full
// rounds on the feedback register. Pass NUM_ROUNDS is the final round, which
// skips MixColumns.
// A pass that never completes is abandoned after TIMEOUT wait cycles. This
// sets the sticky err flag.
// Every output is decoded from the registered state and round counter only,
// so no input reaches an output combinationally.

module aes_round_ctrl #(
    parameter int NUM_ROUNDS = 10,
    parameter int KEY_IDX_W  = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 abort,
    output logic                 dp_start,
    input  logic                 dp_done,
    output logic                 load_sel,
    output logic                 ark_only,
    output logic                 mix_bypass,
    output logic [KEY_IDX_W-1:0] key_idx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 err
);

    // The wait counter only has to reach TIMEOUT-1. TIMEOUT >= 2 keeps this at least 1 bit.
    localparam int WCNT_W = $clog2(TIMEOUT);

    localparam logic [KEY_IDX_W-1:0] LAST_RND  = KEY_IDX_W'(NUM_ROUNDS);
    localparam logic [WCNT_W-1:0]    WCNT_LAST = WCNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [KEY_IDX_W-1:0]  rnd;
    logic [KEY_IDX_W-1:0]  rnd_next;
    logic [WCNT_W-1:0]     wcnt;
    logic [WCNT_W-1:0]     wcnt_next;
    logic                  err_next;

    // State, round counter, wait counter and sticky error register.
    // Asserting reset drops any block in flight immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            rnd   <= '0;
            wcnt  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            rnd   <= rnd_next;
            wcnt  <= wcnt_next;
            err   <= err_next;
        end
    end

    // Next-state logic and Moore output decode.
    always_comb begin
        state_next = state;
        rnd_next   = rnd;
        wcnt_next  = wcnt;
        err_next   = err;

        in_ready   = 1'b0;
        dp_start   = 1'b0;
        load_sel   = 1'b0;
        ark_only   = 1'b0;
        mix_bypass = 1'b0;
        key_idx    = '0;
        out_valid  = 1'b0;

        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                // Accepting a block clears the error flag.
                // abort is not looked at while idle.
                if (in_valid) begin
                    state_next = ISSUE;
                    rnd_next   = '0;
                    err_next   = 1'b0;
                end
            end

            ISSUE: begin
                dp_start   = 1'b1;
                key_idx    = rnd;
                load_sel   = (rnd == '0);
                ark_only   = (rnd == '0);
                mix_bypass = (rnd == LAST_RND);
                if (abort) begin
                    state_next = IDLE;
                    rnd_next   = '0;
                end else begin
                    state_next = WAIT;
                    wcnt_next  = '0;
                end
            end

            WAIT: begin
                // The datapath may still be using these controls, so hold them until the pass completes.
                key_idx    = rnd;
                load_sel   = (rnd == '0);
                ark_only   = (rnd == '0);
                mix_bypass = (rnd == LAST_RND);
                if (abort) begin
                    state_next = IDLE;
                    rnd_next   = '0;
                end else if (dp_done) begin
                    if (rnd == LAST_RND) begin
                        state_next = DONE;
                    end else begin
                        state_next = ISSUE;
                        rnd_next   = rnd + KEY_IDX_W'(1);
                    end
                end else if (wcnt == WCNT_LAST) begin
                    state_next = IDLE;
                    rnd_next   = '0;
                    err_next   = 1'b1;
                end else begin
                    wcnt_next = wcnt + WCNT_W'(1);
                end
            end

            DONE: begin
                out_valid = 1'b1;
                if (abort || out_ready) begin
                    state_next = IDLE;
                    rnd_next   = '0;
                end
            end

            default: begin
                state_next = IDLE;
                rnd_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: drives aes_round_ctrl with an emulated datapath of
// adjustable latency. A latency-formula reference model predicts every cycle
// of each block.
module tb_aes_round_ctrl;

    localparam int N  = 10;
    localparam int KW = 4;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          abort;
    logic          dp_start;
    logic          dp_done;
    logic          load_sel;
    logic          ark_only;
    logic          mix_bypass;
    logic [KW-1:0] key_idx;
    logic          out_valid;
    logic          out_ready;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;
    int lat   = 1;
    int cnt   = 0;
    bit auto_en = 1'b1;

    always #5 clk = ~clk;

    aes_round_ctrl #(.NUM_ROUNDS(N), .KEY_IDX_W(KW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .abort(abort), .dp_start(dp_start), .dp_done(dp_done),
        .load_sel(load_sel), .ark_only(ark_only), .mix_bypass(mix_bypass),
        .key_idx(key_idx), .out_valid(out_valid), .out_ready(out_ready), .err(err)
    );

    // Advance one clock, then settle 1 time unit past the edge.
    // This also emulates a datapath that raises dp_done lat cycles after it sees dp_start.
    task automatic step();
        logic started;
        started = dp_start;
        @(posedge clk);
        #1;
        if (started) cnt = lat;
        else if (cnt > 0) cnt--;
        if (auto_en) dp_done = (cnt == 1);
    endtask

    // Reference model: the cycle (relative to acceptance) at which each round is issued.
    function automatic bit exp_issue(int kk, int l);
        return (kk >= 1) && (((kk - 1) % (l + 1)) == 0) && (((kk - 1) / (l + 1)) <= N);
    endfunction

    // Reference model: the first cycle at which out_valid is raised.
    function automatic int ov_cycle(int l);
        return 2 + N * (l + 1) + l;
    endfunction

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0; dp_done = 1'b0;
        #3;
        n_cmp++;
        if ({in_ready, dp_start, out_valid, err, load_sel, ark_only, mix_bypass, key_idx} !== {4'b1000, 3'b000, 4'd0})
            begin n_bad++; $display("FAIL reset_outputs: got %b_%b%b%b%b%b%b_%h want 1_000000_0",
                  in_ready, dp_start, out_valid, err, load_sel, ark_only, mix_bypass, key_idx); end
        step(); step();
        reset = 1'b1;
        step();
        n_cmp++;
        if ({in_ready, dp_start, out_valid, err} !== 4'b1000)
            begin n_bad++; $display("FAIL reset_release: got %b%b%b%b want 1000", in_ready, dp_start, out_valid, err); end
    endtask

    task automatic test_single_block();
        bit es, eo, ei;
        int r;
        lat = 1; out_ready = 1'b1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL single_idle_ready: got %b want 1", in_ready); end
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            es = (k <= 21) && (k % 2 == 1);
            eo = (k == 23);
            ei = (k == 24);
            n_cmp++;
            if ({dp_start, out_valid, in_ready} !== {es, eo, ei})
                begin n_bad++; $display("FAIL single_k%0d start/ov/ready: got %b%b%b want %b%b%b",
                      k, dp_start, out_valid, in_ready, es, eo, ei); end
            if (es) begin
                r = (k - 1) / 2;
                n_cmp++;
                if ({key_idx, ark_only, mix_bypass, load_sel} !== {KW'(r), (r == 0), (r == N), (r == 0)})
                    begin n_bad++; $display("FAIL single_k%0d key/ark/mix/load: got %0d %b%b%b want %0d %b%b%b",
                          k, key_idx, ark_only, mix_bypass, load_sel, r, (r == 0), (r == N), (r == 0)); end
            end
            if (k < 24) step();
        end
    endtask

    task automatic test_backpressure();
        bit eo, ei;
        lat = 1; out_ready = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 29; k++) begin
            eo = (k >= 23) && (k <= 28);
            ei = (k == 29);
            n_cmp++;
            if ({out_valid, in_ready} !== {eo, ei})
                begin n_bad++; $display("FAIL backpressure_k%0d ov/ready: got %b%b want %b%b", k, out_valid, in_ready, eo, ei); end
            out_ready = (k == 28);
            if (k < 29) step();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_timeout();
        bit es, ei, ee;
        auto_en = 1'b0; dp_done = 1'b0; out_ready = 1'b1; cnt = 0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= TO + 2; k++) begin
            es = (k == 1);
            ei = (k == TO + 2);
            ee = (k == TO + 2);
            n_cmp++;
            if ({dp_start, in_ready, err} !== {es, ei, ee})
                begin n_bad++; $display("FAIL timeout_k%0d start/ready/err: got %b%b%b want %b%b%b",
                      k, dp_start, in_ready, err, es, ei, ee); end
            if (k < TO + 2) step();
        end
        step(); step(); step();
        n_cmp++;
        if ({err, in_ready} !== 2'b11) begin n_bad++; $display("FAIL timeout_sticky: got err=%b ready=%b want 11", err, in_ready); end
        auto_en = 1'b1; cnt = 0; dp_done = 1'b0; lat = 1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            n_cmp++;
            if ({err, out_valid, in_ready} !== {1'b0, (k == 23), (k == 24)})
                begin n_bad++; $display("FAIL timeout_recover_k%0d err/ov/ready: got %b%b%b want 0%b%b",
                      k, err, out_valid, in_ready, (k == 23), (k == 24)); end
            if (k < 24) step();
        end
    endtask

    task automatic test_abort();
        bit bad;
        lat = 1; out_ready = 1'b1;
        // Abort during round 5 WAIT, in the same cycle the datapath reports completion.
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 1; k < 12; k++) step();
        n_cmp++;
        if ({dp_start, key_idx} !== {1'b0, KW'(5)})
            begin n_bad++; $display("FAIL abort_pre: got start=%b key=%0d want 0 5", dp_start, key_idx); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_cmp++;
        if ({in_ready, dp_start, out_valid, err} !== 4'b1000)
            begin n_bad++; $display("FAIL abort_wait: got %b%b%b%b want 1000", in_ready, dp_start, out_valid, err); end
        bad = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (dp_start !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
        end
        n_cmp++;
        if (bad !== 1'b0) begin n_bad++; $display("FAIL abort_quiet: got activity=%b want 0", bad); end
        // Abort while out_valid is being held in DONE.
        out_ready = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 1; k < 23; k++) step();
        n_cmp++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL abort_done_pre: got ov=%b want 1", out_valid); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10)
            begin n_bad++; $display("FAIL abort_done: got ready=%b ov=%b want 10", in_ready, out_valid); end
        // In IDLE, abort has no effect and the block is still accepted.
        out_ready = 1'b1;
        abort = 1'b1; in_valid = 1'b1;
        step();
        abort = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if ({dp_start, key_idx, in_ready} !== {1'b1, KW'(0), 1'b0})
            begin n_bad++; $display("FAIL abort_idle: got start=%b key=%0d ready=%b want 1 0 0", dp_start, key_idx, in_ready); end
        for (int k = 2; k <= 24; k++) step();
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL abort_idle_finish: got ready=%b want 1", in_ready); end
    endtask

    task automatic test_spurious();
        bit es, eo, ei;
        int o;
        lat = 2; out_ready = 1'b0;
        o = ov_cycle(2);
        dp_done = 1'b1;
        step();
        n_cmp++;
        if ({in_ready, dp_start} !== 2'b10)
            begin n_bad++; $display("FAIL spurious_idle: got ready=%b start=%b want 10", in_ready, dp_start); end
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= o + 3; k++) begin
            es = exp_issue(k, 2);
            eo = (k >= o) && (k <= o + 2);
            ei = (k == o + 3);
            n_cmp++;
            if ({dp_start, out_valid, in_ready} !== {es, eo, ei})
                begin n_bad++; $display("FAIL spurious_k%0d start/ov/ready: got %b%b%b want %b%b%b",
                      k, dp_start, out_valid, in_ready, es, eo, ei); end
            if (es) begin
                n_cmp++;
                if (key_idx !== KW'((k - 1) / 3))
                    begin n_bad++; $display("FAIL spurious_k%0d key: got %0d want %0d", k, key_idx, (k - 1) / 3); end
            end
            if (es || eo) dp_done = 1'b1;
            out_ready = (k == o + 2);
            if (k < o + 3) step();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        bit es, eo, ei;
        lat = 1; out_ready = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 1; k < 15; k++) step();
        n_cmp++;
        if ({dp_start, key_idx} !== {1'b1, KW'(7)})
            begin n_bad++; $display("FAIL areset_pre: got start=%b key=%0d want 1 7", dp_start, key_idx); end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, dp_start, out_valid, key_idx} !== {3'b100, KW'(0)})
            begin n_bad++; $display("FAIL areset_immediate: got %b%b%b key=%0d want 100 0", in_ready, dp_start, out_valid, key_idx); end
        step();
        reset = 1'b1; cnt = 0; dp_done = 1'b0;
        step();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            es = exp_issue(k, 1);
            eo = (k == 23);
            ei = (k == 24);
            n_cmp++;
            if ({dp_start, out_valid, in_ready} !== {es, eo, ei})
                begin n_bad++; $display("FAIL areset_next_k%0d start/ov/ready: got %b%b%b want %b%b%b",
                      k, dp_start, out_valid, in_ready, es, eo, ei); end
            if (es) begin
                n_cmp++;
                if (key_idx !== KW'((k - 1) / 2))
                    begin n_bad++; $display("FAIL areset_next_k%0d key: got %0d want %0d", k, key_idx, (k - 1) / 2); end
            end
            if (k < 24) step();
        end
    endtask

    task automatic test_back_to_back();
        bit es, ei;
        int l, o, kk;
        l = $urandom_range(1, 3);
        lat = l; out_ready = 1'b1;
        o = ov_cycle(l);
        in_valid = 1'b1;
        step();
        for (int k = 1; k <= 2 * (o + 1); k++) begin
            kk = (k <= o + 1) ? k : k - (o + 1);
            es = exp_issue(kk, l);
            ei = (kk == o + 1);
            n_cmp++;
            if ({dp_start, in_ready, out_valid} !== {es, ei, (kk == o)})
                begin n_bad++; $display("FAIL b2b_L%0d_k%0d start/ready/ov: got %b%b%b want %b%b%b",
                      l, k, dp_start, in_ready, out_valid, es, ei, (kk == o)); end
            if (k >= o + 2) in_valid = 1'b0;
            if (k < 2 * (o + 1)) step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_random_blocks();
        bit es, eo, ei;
        int l, d, gap, o, r;
        for (int b = 0; b < 8; b++) begin
            l = $urandom_range(1, 3);
            d = $urandom_range(0, 4);
            gap = $urandom_range(0, 3);
            lat = l; out_ready = 1'b0;
            o = ov_cycle(l);
            for (int g = 0; g < gap; g++) step();
            n_cmp++;
            if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rand%0d_idle: got ready=%b want 1", b, in_ready); end
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            for (int k = 1; k <= o + d + 1; k++) begin
                es = exp_issue(k, l);
                eo = (k >= o) && (k <= o + d);
                ei = (k == o + d + 1);
                n_cmp++;
                if ({dp_start, out_valid, in_ready} !== {es, eo, ei})
                    begin n_bad++; $display("FAIL rand%0d_L%0d_D%0d_k%0d start/ov/ready: got %b%b%b want %b%b%b",
                          b, l, d, k, dp_start, out_valid, in_ready, es, eo, ei); end
                if (k < o) begin
                    r = (k - 1) / (l + 1);
                    n_cmp++;
                    if ({key_idx, load_sel, ark_only, mix_bypass} !== {KW'(r), (r == 0), (r == 0), (r == N)})
                        begin n_bad++; $display("FAIL rand%0d_k%0d key/load/ark/mix: got %0d %b%b%b want %0d %b%b%b",
                              b, k, key_idx, load_sel, ark_only, mix_bypass, r, (r == 0), (r == 0), (r == N)); end
                end
                out_ready = (k < o) ? 1'($urandom_range(0, 1)) : (k == o + d);
                if (k < o + d + 1) step();
            end
            out_ready = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t exceeded bound, want completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_block();
        test_backpressure();
        test_timeout();
        test_abort();
        test_spurious();
        test_async_reset();
        test_back_to_back();
        test_random_blocks();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
